frame_tx_scheduler: RTL and testbench
=====================================

# frame_tx_scheduler

Round-robin scheduler that shares the single 56-bit frame serializer between NUM_CH 32-bit word producers in the clk_sys domain. It grants one requester at a time and presents the chosen word plus channel index to the frame assembly stage through a valid/ready handshake. When the link has been silent for a programmable period, it injects keep-alive words so the receiver's frame sync never drops.

## Interface
- NUM_CH, 4: number of requesting channels (2..8)
- CH_W, 2: width of channel index, = clog2(NUM_CH)
- KEEPALIVE_CYC, 1024: idle clk_sys cycles before a keep-alive is issued (≥4)
- clk_sys  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- req_data  in  NUM_CH*32  per-channel word; channel i at [32*i+31:32*i]
- req_valid  in  NUM_CH  per-channel word available
- req_ready  out  NUM_CH  one-hot grant/accept strobe (combinational)
- en_mask  in  NUM_CH  channel enable; disabled channels are never granted
- out_data  out  32  word to frame assembly
- out_ch  out  CH_W  source channel of out_data
- out_keepalive  out  1  out_data is a keep-alive filler
- out_valid  out  1  out_data/out_ch/out_keepalive valid
- out_ready  in  1  frame assembly accepts word
- tx_words  out  16  count of completed output handshakes, wraps

## Operation
- States: IDLE, SEND.
- IDLE: eligible = req_valid & en_mask. If nonzero, the winner is the first set bit searched from (last_grant+1) mod NUM_CH upward with wrap. req_ready[winner]=1 for this cycle only. Capture req_data[winner] into out_data and winner into out_ch. Clear out_keepalive, set last_grant=winner, go to SEND.
- SEND: out_valid=1; out_data/out_ch/out_keepalive held stable. On out_valid&out_ready: tx_words+1, go to IDLE. No abort; en_mask changes do not affect a word in SEND.
- req_ready is all-zero in SEND and while rst is high.
- Keep-alive: idle_cnt increments each IDLE cycle with eligible==0. Cleared on any output handshake and in SEND.
  - When idle_cnt==KEEPALIVE_CYC-1 and eligible==0: load out_data=32'h0000_0000, out_ch=0, out_keepalive=1, go to SEND. last_grant is unchanged.
  - Request and expiry in the same cycle: the request wins and no keep-alive is sent.
- tx_words counts data and keep-alive words and wraps 0xFFFF→0.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, out_keepalive=0, tx_words=0, req_ready=0, state=IDLE, idle_cnt=0, last_grant=NUM_CH-1 (channel 0 has first priority).
- Reset asserted mid-SEND: out_valid drops asynchronously and the word is discarded.
- Latency: req_valid seen in IDLE at cycle N gives req_ready at N (same cycle) and out_valid at N+1.
- Throughput: at most 1 word per 2 cycles (the IDLE cycle between grants).
- A producer must hold req_valid/req_data until it sees req_ready. Deasserting req_valid before the grant is legal, and the channel is then simply not eligible.
- Keep-alive spacing: the first keep-alive out_valid appears KEEPALIVE_CYC cycles after the last handshake, or after reset release.

## Configuration
- FRAME_SCHED_KEEPALIVE_EN defined: keep-alive logic as above.
- FRAME_SCHED_KEEPALIVE_EN undefined: idle_cnt is removed, out_keepalive is tied 0, and the block only emits granted words. KEEPALIVE_CYC is ignored.

## Test plan
- All 4 channels valid continuously with data 0x1000_000i, en_mask=4'hF, out_ready=1 → out_ch sequence 0,1,2,3,0,…; out_valid 1 cycle after each grant; tx_words increments by 1 per word.
- Channel 2 only valid with out_ready held 0 for 10 cycles → out_valid stays 1; out_data stays 0x1000_0002 with no change; req_ready all-zero throughout; handshake on the first cycle out_ready=1.
- en_mask=4'b1010 with all channels valid → only channels 1 and 3 are granted, alternating.
- No requests, KEEPALIVE_CYC=16 → keep-alive out_valid (out_keepalive=1, out_data=0) 16 cycles after reset release, then every 17 cycles with out_ready=1. A request landing on the expiry cycle produces a data word and no keep-alive.
- Reset pulse during SEND → out_valid=0 immediately; after release, channel 0 wins when all channels are valid.
- tx_words preloaded by 0xFFFF handshakes → the next handshake wraps it to 0.

Source files
------------

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
//   Round-robin scheduler sharing one frame serializer between NUM_CH word
//   producers. One requester is granted per IDLE cycle; the captured word is
//   presented on a valid/ready handshake to the frame assembly stage.
//   Optional keep-alive filler words are enabled by defining the macro
//   FRAME_SCHED_KEEPALIVE_EN; without it out_keepalive is tied low and only
//   granted words are emitted.
// Ports:
//   clk_sys        system clock
//   rst            asynchronous active-high reset
//   req_data       per-channel 32-bit words, channel i at [32*i+31:32*i]
//   req_valid      per-channel word available
//   req_ready      one-hot grant strobe (combinational, IDLE only)
//   en_mask        channel enable; disabled channels are never granted
//   out_data       word to frame assembly
//   out_ch         source channel of out_data
//   out_keepalive  out_data is a keep-alive filler
//   out_valid      output word valid
//   out_ready      frame assembly accepts word
//   tx_words       completed output handshakes, wraps at 16 bits
module frame_tx_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int KEEPALIVE_CYC = 1024
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [NUM_CH*32-1:0] req_data,
  input  logic [NUM_CH-1:0]    req_valid,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic [NUM_CH-1:0]    en_mask,
  output logic [31:0]          out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_keepalive,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          tx_words
);

  if (CH_W != $clog2(NUM_CH) || NUM_CH < 2 || NUM_CH > 8 || KEEPALIVE_CYC < 4) begin : g_param_check
    $error("frame_tx_scheduler: illegal parameter combination");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [15:0]       tx_words_q, tx_words_d;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic              found;
  logic [CH_W-1:0]   winner;

`ifdef FRAME_SCHED_KEEPALIVE_EN
  localparam int IDLE_W = $clog2(KEEPALIVE_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(KEEPALIVE_CYC - 1);

  logic              out_keepalive_q, out_keepalive_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // Rotating priority: search starts one past the last granted channel.
  always_comb begin
    int unsigned cand;
    eligible = req_valid & en_mask;
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = (32'(last_grant_q) + k) % NUM_CH;
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = CH_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    tx_words_d   = tx_words_q;
    grant        = '0;
`ifdef FRAME_SCHED_KEEPALIVE_EN
    out_keepalive_d = out_keepalive_q;
    // Held at zero in SEND and whenever a word is granted.
    idle_cnt_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant[winner] = 1'b1;
          out_data_d    = req_data[32*int'(winner) +: 32];
          out_ch_d      = winner;
          last_grant_d  = winner;
          state_d       = SEND;
`ifdef FRAME_SCHED_KEEPALIVE_EN
          out_keepalive_d = 1'b0;
`endif
        end
`ifdef FRAME_SCHED_KEEPALIVE_EN
        else if (idle_cnt_q == IDLE_LAST) begin
          out_data_d      = '0;
          out_ch_d        = '0;
          out_keepalive_d = 1'b1;
          state_d         = SEND;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (out_ready) begin
          tx_words_d = tx_words_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      tx_words_q   <= '0;
`ifdef FRAME_SCHED_KEEPALIVE_EN
      out_keepalive_q <= 1'b0;
      idle_cnt_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
      tx_words_q   <= tx_words_d;
`ifdef FRAME_SCHED_KEEPALIVE_EN
      out_keepalive_q <= out_keepalive_d;
      idle_cnt_q      <= idle_cnt_d;
`endif
    end
  end

  // Grant is masked directly by rst so it is silent throughout reset.
  assign req_ready = grant & {NUM_CH{~rst}};
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign tx_words  = tx_words_q;
`ifdef FRAME_SCHED_KEEPALIVE_EN
  assign out_keepalive = out_keepalive_q;
`else
  assign out_keepalive = 1'b0;
`endif

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Testbench for frame_tx_scheduler with a transaction-level reference model.
module tb_frame_tx_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int KA     = 16;
`ifdef FRAME_SCHED_KEEPALIVE_EN
  localparam bit KA_EN = 1'b1;
`else
  localparam bit KA_EN = 1'b0;
`endif

  logic                 clk_sys = 1'b0;
  logic                 rst;
  logic [NUM_CH*32-1:0] req_data;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH-1:0]    en_mask;
  logic [31:0]          out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 out_keepalive;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          tx_words;

  int n_checks = 0;
  int n_fail   = 0;

  frame_tx_scheduler #(
    .NUM_CH        (NUM_CH),
    .CH_W          (CH_W),
    .KEEPALIVE_CYC (KA)
  ) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .en_mask       (en_mask),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .out_keepalive (out_keepalive),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .tx_words      (tx_words)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: one pending word slot, rotating priority pointer,
  // silence counter and a modulo-65536 word counter.
  bit          m_busy;
  logic [31:0] m_word;
  int          m_ch;
  bit          m_ka;
  int          m_last;
  int          m_idle;
  int          m_tx;

  function automatic int pick(input logic [NUM_CH-1:0] elig);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_last + k) % NUM_CH;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [55:0] expect_vec();
    logic [NUM_CH-1:0] rdy;
    int w;
    rdy = '0;
    w   = pick(req_valid & en_mask);
    if (!rst && !m_busy && w >= 0) rdy[w] = 1'b1;
    return {rdy, m_busy, m_word, 2'(m_ch), m_ka, 16'(m_tx)};
  endfunction

  function automatic logic [55:0] obs_vec();
    return {req_ready, out_valid, out_data, out_ch, out_keepalive, tx_words};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_word = '0; m_ch = 0; m_ka = 0;
    m_last = NUM_CH - 1; m_idle = 0; m_tx = 0;
  endtask

  task automatic model_advance();
    int w;
    if (m_busy) begin
      m_idle = 0;
      if (out_ready) begin
        m_tx   = (m_tx + 1) % 65536;
        m_busy = 0;
      end
    end else begin
      w = pick(req_valid & en_mask);
      if (w >= 0) begin
        m_word = req_data[32*w +: 32];
        m_ch = w; m_ka = 0; m_last = w; m_busy = 1; m_idle = 0;
      end else if (KA_EN) begin
        if (m_idle == KA - 1) begin
          m_word = '0; m_ch = 0; m_ka = 1; m_busy = 1; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_advance();
    @(negedge clk_sys);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk_sys);
    rst = 1'b0;
  endtask

  task automatic set_words();
    for (int i = 0; i < NUM_CH; i++) req_data[32*i +: 32] = 32'h1000_0000 + i;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      req_valid = 4'(($urandom % 15) + 1);
      en_mask   = 4'hF;
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom);
      #1;
      n_checks++;
      if (obs_vec() !== {4'b0, 1'b0, 32'h0, 2'd0, 1'b0, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_state: got %h expected %h", obs_vec(), {4'b0, 1'b0, 32'h0, 2'd0, 1'b0, 16'h0});
      end
    end
    req_valid = '0;
    @(negedge clk_sys);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int seq;
    seq = 0;
    en_mask = 4'hF; out_ready = 1'b1; req_valid = '0; set_words();
    apply_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 24; c++) begin
      #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL round_robin cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_ch !== 2'(seq % NUM_CH) || out_data !== 32'h1000_0000 + 32'(seq % NUM_CH)) begin
          n_fail++;
          $display("FAIL rr_sequence word %0d: got ch %0d data %h expected ch %0d", seq, out_ch, out_data, seq % NUM_CH);
        end
        seq++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    en_mask = 4'hF; out_ready = 1'b0; req_valid = '0; set_words();
    apply_reset();
    req_valid = 4'b0100;
    for (int c = 0; c < 16; c++) begin
      if (req_ready[2]) req_valid = '0;
      out_ready = (c >= 11);
      #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL backpressure cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      if (c >= 1 && c <= 11) begin
        held = 32'h1000_0002;
        n_checks++;
        if (!out_valid || out_data !== held || req_ready !== '0) begin
          n_fail++;
          $display("FAIL backpressure_hold cyc %0d: got valid %b data %h ready %b expected 1 %h 0000", c, out_valid, out_data, req_ready, held);
        end
      end
      tick();
    end
  endtask

  task automatic test_mask();
    int seq;
    seq = 0;
    en_mask = 4'b1010; out_ready = 1'b1; req_valid = '0; set_words();
    apply_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL mask cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_ch !== ((seq % 2 == 0) ? 2'd1 : 2'd3)) begin
          n_fail++;
          $display("FAIL mask_sequence word %0d: got ch %0d expected %0d", seq, out_ch, (seq % 2 == 0) ? 1 : 3);
        end
        seq++;
      end
      tick();
    end
  endtask

  task automatic test_keepalive();
    int first_ka;
    bit armed;
    first_ka = -1; armed = 0;
    en_mask = 4'hF; out_ready = 1'b1; req_valid = '0; set_words();
    apply_reset();
    for (int c = 0; c < 90; c++) begin
      if (req_ready[1]) req_valid = '0;
      // After a couple of keep-alives, land a request exactly on expiry.
      if (KA_EN && c > 40 && !armed && !m_busy && m_idle == KA - 1) begin
        req_valid = 4'b0010;
        armed = 1;
      end
      #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL keepalive cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      if (out_valid && first_ka < 0) first_ka = c;
      tick();
    end
    n_checks++;
    if (first_ka !== (KA_EN ? KA : -1)) begin
      n_fail++;
      $display("FAIL keepalive_first: got cycle %0d expected %0d", first_ka, KA_EN ? KA : -1);
    end
  endtask

  task automatic test_reset_mid_send();
    en_mask = 4'hF; out_ready = 1'b0; req_valid = '0; set_words();
    apply_reset();
    req_valid = 4'hF;
    tick(); tick(); tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || req_ready !== '0 || obs_vec() !== expect_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_send: got %h expected %h", obs_vec(), expect_vec());
    end
    @(negedge clk_sys);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
    end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1; req_valid = '0;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = 4'($urandom);
      en_mask   = 4'($urandom | $urandom);
      out_ready = ($urandom % 4) != 0;
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      if (c % 300 < 40) req_valid = '0;
      #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      tick();
    end
  endtask

  task automatic test_tx_wrap();
    bit saw_zero;
    saw_zero = 0;
    en_mask = 4'hF; out_ready = 1'b1; req_valid = '0; set_words();
    apply_reset();
    force dut.tx_words_q = 16'hFFFE;
    m_tx = 16'hFFFE;
    #1;
    release dut.tx_words_q;
    @(negedge clk_sys);
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if (obs_vec() !== expect_vec()) begin
        n_fail++;
        $display("FAIL tx_wrap cyc %0d: got %h expected %h", c, obs_vec(), expect_vec());
      end
      if (c > 2 && tx_words == 16'h0000) saw_zero = 1;
      tick();
    end
    n_checks++;
    if (!saw_zero) begin
      n_fail++;
      $display("FAIL tx_wrap_zero: got no wrap to 0000 expected 0000 after ffff");
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; en_mask = '0; req_data = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_keepalive();
    test_reset_mid_send();
    test_random();
    test_tx_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
